// File: rtl/key_press_gen.sv
// -----------------------------------------------------------------------------
// key_press_gen
//
// Turns single-cycle press requests into level-shaped button waveforms.
// Each press holds out high for HOLD_CYCLES, then low for at least
// GAP_CYCLES, so a synchronizing edge detector downstream sees exactly one
// press per request. Requests arriving while a press is running are counted
// and replayed in order.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   reset     in   synchronous active-low reset
//   req       in   press request, one request per high cycle
//   out       out  emulated button level (registered)
//   busy      out  FSM not IDLE (registered, follows next state)
//   pending   out  queued requests not yet started (registered)
//   overflow  out  request dropped (registered)
//
// Build option:
//   KEY_PRESS_GEN_STICKY_OVF_EN  defined   -> overflow sticky until reset
//                                undefined -> overflow pulses per dropped req
//
// States:
//   IDLE  | no press in progress, out low
//   PRESS | out high, timer counts down the hold time
//   GAP   | out low, timer counts down the minimum release time
// -----------------------------------------------------------------------------
module key_press_gen #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 4,
   parameter int MAX_PENDING = 7
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req,
   output logic                             out,
   output logic                             busy,
   output logic [$clog2(MAX_PENDING+1)-1:0] pending,
   output logic                             overflow
);

   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PW   = $clog2(MAX_PENDING + 1);

   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_timer;
   logic [TW-1:0]   w_timer_nxt;
   logic [PW-1:0]   r_pending;
   logic [PW-1:0]   w_pending_nxt;
   logic            r_out;
   logic            r_busy;
   logic            r_ovf;

   logic            w_start;
   logic            w_pend_nz;
   logic            w_tc;
   logic            w_take_pend;
   logic            w_take_req;
   logic            w_req_left;
   logic            w_inc;
   logic            w_drop;
   logic            w_ovf_nxt;

   assign w_pend_nz = (r_pending != '0);
   assign w_tc      = (r_timer == '0);

   // Next-state and timer
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req || w_pend_nz) begin
               w_start     = 1'b1;
               w_state_nxt = ST_PRESS;
               w_timer_nxt = HOLD_LOAD;
            end
         end
         ST_PRESS: begin
            if (w_tc) begin
               w_state_nxt = ST_GAP;
               w_timer_nxt = GAP_LOAD;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         ST_GAP: begin
            if (w_tc) begin
               if (req || w_pend_nz) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_PRESS;
                  w_timer_nxt = HOLD_LOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   // A start serves the oldest queued request first; the incoming req is
   // only taken directly when the queue is empty.
   assign w_take_pend = w_start && w_pend_nz;
   assign w_take_req  = w_start && !w_pend_nz;
   assign w_req_left  = req && !w_take_req;

   // Fullness is judged on the current count: a req arriving at a full queue
   // is dropped even if a start frees a slot on the same edge.
   assign w_inc  = w_req_left && (r_pending != PEND_MAX);
   assign w_drop = w_req_left && (r_pending == PEND_MAX);

   always_comb begin
      w_pending_nxt = r_pending;
      case ({w_inc, w_take_pend})
         2'b10:   w_pending_nxt = r_pending + 1'b1;
         2'b01:   w_pending_nxt = r_pending - 1'b1;
         default: w_pending_nxt = r_pending;
      endcase
   end

`ifdef KEY_PRESS_GEN_STICKY_OVF_EN
   assign w_ovf_nxt = r_ovf | w_drop;
`else
   assign w_ovf_nxt = w_drop;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_timer   <= '0;
         r_pending <= '0;
         r_out     <= 1'b0;
         r_busy    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_pending <= w_pending_nxt;
         r_out     <= (w_state_nxt == ST_PRESS);
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_ovf     <= w_ovf_nxt;
      end
   end

   assign out      = r_out;
   assign busy     = r_busy;
   assign pending  = r_pending;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_key_press_gen.sv
module tb_key_press_gen;

   localparam int PW = 3;

   logic          clk;
   logic          reset;
   logic          req;
   logic          out;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   int checks;
   int errors;
   int rises;
   logic prev_out;

   key_press_gen #(
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (4),
      .MAX_PENDING (7)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .out      (out),
      .busy     (busy),
      .pending  (pending),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge with given inputs; outputs sampled 1 time unit later.
   task automatic step(input logic r, input logic rst);
      req   = r;
      reset = rst;
      @(posedge clk);
      #1;
      if (out && !prev_out) rises++;
      prev_out = out;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      rises = 0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rises    = 0;
      prev_out = 1'b0;
      req      = 1'b0;
      reset    = 1'b0;
      #1;

      // 1: reset held with req high
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("rst_out", int'(out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pend", int'(pending), 0);
      chk("rst_ovf", int'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1);
         chk("idle_out", int'(out), 0);
         chk("idle_busy", int'(busy), 0);
      end

      // 2: single request, request edge is n=0
      rises = 0;
      for (int n = 0; n < 12; n++) begin
         step(n == 0, 1'b1);
         chk("t2_out", int'(out), (n <= 3) ? 1 : 0);
         chk("t2_busy", int'(busy), (n <= 7) ? 1 : 0);
         chk("t2_pend", int'(pending), 0);
      end
      chk("t2_presses", rises, 1);

      // 3: three back-to-back requests
      do_reset();
      for (int n = 0; n < 28; n++) begin
         int ep;
         step(n < 3, 1'b1);
         if (n == 0)       ep = 0;
         else if (n == 1)  ep = 1;
         else if (n < 8)   ep = 2;
         else if (n < 16)  ep = 1;
         else              ep = 0;
         chk("t3_pend", int'(pending), ep);
         chk("t3_out", int'(out), (n < 24 && (n % 8) < 4) ? 1 : 0);
         chk("t3_busy", int'(busy), (n < 24) ? 1 : 0);
      end
      chk("t3_presses", rises, 3);

      // 4: nine consecutive requests from IDLE, ninth dropped
      do_reset();
      for (int n = 0; n < 68; n++) begin
         int ep;
         step(n < 9, 1'b1);
         if (n < 8)  ep = n;
         else if (n < 64) ep = 7 - n / 8;
         else ep = 0;
         chk("t4_pend", int'(pending), ep);
         chk("t4_out", int'(out), (n < 64 && (n % 8) < 4) ? 1 : 0);
         if (n < 8) chk("t4_ovf_lo", int'(overflow), 0);
         if (n == 8) chk("t4_ovf_drop", int'(overflow), 1);
`ifdef KEY_PRESS_GEN_STICKY_OVF_EN
         if (n > 8) chk("t4_ovf_after", int'(overflow), 1);
`else
         if (n > 8) chk("t4_ovf_after", int'(overflow), 0);
`endif
      end
      chk("t4_presses", rises, 8);
      chk("t4_busy_end", int'(busy), 0);

      // 5: consume from queue and enqueue on the same (final GAP) edge
      do_reset();
      for (int n = 0; n < 28; n++) begin
         int ep;
         step(n == 0 || n == 1 || n == 8, 1'b1);
         if (n == 0)      ep = 0;
         else if (n < 16) ep = 1;
         else             ep = 0;
         chk("t5_pend", int'(pending), ep);
         chk("t5_out", int'(out), (n < 24 && (n % 8) < 4) ? 1 : 0);
         chk("t5_ovf", int'(overflow), 0);
      end
      chk("t5_presses", rises, 3);

      // 6: reset during a press with three queued
      do_reset();
      for (int n = 0; n < 4; n++) step(1'b1, 1'b1);
      chk("t6_pre_pend", int'(pending), 3);
      chk("t6_pre_out", int'(out), 1);
      step(1'b0, 1'b0);
      chk("t6_out", int'(out), 0);
      chk("t6_pend", int'(pending), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_ovf", int'(overflow), 0);
      rises = 0;
      for (int n = 0; n < 20; n++) begin
         step(1'b0, 1'b1);
         chk("t6_quiet_busy", int'(busy), 0);
      end
      chk("t6_presses", rises, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
